// File: rtl/rms_sqrt_scheduler.sv
// Round-robin scheduler that shares one pipelined square-root core among N_CH
// RMS channels, tagging each issue and steering the returned root to its channel.
module rms_sqrt_scheduler #(
  parameter int N_CH     = 4,
  parameter int RAD_W    = 22,
  parameter int Q_W      = 11,
  parameter int SQRT_LAT = 3
) (
  input  logic                  clk_fs,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*RAD_W-1:0] radical_bus,
  output logic [N_CH-1:0]       ack,
  output logic [RAD_W-1:0]      sqrt_radical,
  input  logic [Q_W-1:0]        sqrt_q,
  output logic [N_CH*Q_W-1:0]   rms_bus,
  output logic [N_CH-1:0]       rms_valid,
  output logic                  busy,
  output logic                  irq
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TAG_N = SQRT_LAT + 1;

  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
  } tag_t;

  logic [N_CH-1:0]     ack_q, ack_d;
  logic [RAD_W-1:0]    rad_q, rad_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  tag_t                tag_q [TAG_N];
  tag_t                tag_d [TAG_N];
  logic [N_CH*Q_W-1:0] rms_q, rms_d;
  logic [N_CH-1:0]     vld_q, vld_d;
  logic [N_CH-1:0]     done_q, done_d;
  logic                irq_q, irq_d;

  logic [N_CH-1:0]     elig;
  logic                gnt_found;
  logic [CH_W-1:0]     gnt_ch;
  logic [CH_W:0]       probe;
  logic [RAD_W-1:0]    rad_sel;
  logic                any_tag;

  // The channel acked on the previous edge is masked so a held req re-queues fairly.
  assign elig = en ? (req & ~ack_q) : '0;

  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    probe     = '0;
    for (int i = 0; i < N_CH; i++) begin
      probe = {1'b0, rr_q} + (CH_W+1)'(i);
      if (probe >= (CH_W+1)'(N_CH)) begin
        probe = probe - (CH_W+1)'(N_CH);
      end
      if (!gnt_found && elig[probe[CH_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_ch    = probe[CH_W-1:0];
      end
    end
  end

  always_comb begin
    rad_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_ch == CH_W'(k)) begin
        rad_sel = radical_bus[k*RAD_W +: RAD_W];
      end
    end
  end

  always_comb begin
    ack_d = '0;
    rad_d = rad_q;
    rr_d  = rr_q;
    if (gnt_found) begin
      ack_d[gnt_ch] = 1'b1;
      rad_d         = rad_sel;
      rr_d          = (gnt_ch == CH_W'(N_CH-1)) ? '0 : gnt_ch + CH_W'(1);
    end
  end

  // Tag pipeline runs in lockstep with the external core's latency.
  always_comb begin
    tag_d[0].vld = gnt_found;
    tag_d[0].ch  = gnt_ch;
    for (int s = 1; s < TAG_N; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_comb begin
    rms_d = rms_q;
    vld_d = '0;
    if (tag_q[SQRT_LAT].vld) begin
      for (int k = 0; k < N_CH; k++) begin
        if (tag_q[SQRT_LAT].ch == CH_W'(k)) begin
          rms_d[k*Q_W +: Q_W] = sqrt_q;
          vld_d[k]            = 1'b1;
        end
      end
    end
  end

  // Mask tracks results as they are latched; a result landing on the clear edge survives.
  always_comb begin
    irq_d  = &done_q;
    done_d = (&done_q) ? vld_d : (done_q | vld_d);
  end

  always_comb begin
    any_tag = 1'b0;
    for (int s = 0; s < TAG_N; s++) begin
      any_tag = any_tag | tag_q[s].vld;
    end
  end

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= '0;
      rad_q  <= '0;
      rr_q   <= '0;
      rms_q  <= '0;
      vld_q  <= '0;
      done_q <= '0;
      irq_q  <= 1'b0;
      for (int s = 0; s < TAG_N; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ack_q  <= ack_d;
      rad_q  <= rad_d;
      rr_q   <= rr_d;
      rms_q  <= rms_d;
      vld_q  <= vld_d;
      done_q <= done_d;
      irq_q  <= irq_d;
      for (int s = 0; s < TAG_N; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign ack          = ack_q;
  assign sqrt_radical = rad_q;
  assign rms_bus      = rms_q;
  assign rms_valid    = vld_q;
  assign irq          = irq_q;
  assign busy         = (|req) | any_tag;

endmodule

// File: tb/tb_rms_sqrt_scheduler.sv
// Scoreboard bench for rms_sqrt_scheduler with a behavioural 3-stage floor-sqrt core.
module tb_rms_sqrt_scheduler;

  localparam int N_CH = 4;
  localparam int RAD_W = 22;
  localparam int Q_W = 11;
  localparam int SQRT_LAT = 3;

  logic                  clk_fs = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en = 1'b0;
  logic [N_CH-1:0]       req = '0;
  logic [N_CH*RAD_W-1:0] radical_bus = '0;
  logic [N_CH-1:0]       ack;
  logic [RAD_W-1:0]      sqrt_radical;
  logic [Q_W-1:0]        sqrt_q;
  logic [N_CH*Q_W-1:0]   rms_bus;
  logic [N_CH-1:0]       rms_valid;
  logic                  busy;
  logic                  irq;

  rms_sqrt_scheduler #(.N_CH(N_CH), .RAD_W(RAD_W), .Q_W(Q_W), .SQRT_LAT(SQRT_LAT)) dut (
    .clk_fs(clk_fs), .rst_n(rst_n), .en(en), .req(req), .radical_bus(radical_bus),
    .ack(ack), .sqrt_radical(sqrt_radical), .sqrt_q(sqrt_q), .rms_bus(rms_bus),
    .rms_valid(rms_valid), .busy(busy), .irq(irq)
  );

  always #5 clk_fs = ~clk_fs;

  function automatic int isqrt(input int x);
    int r;
    int t;
    r = 0;
    for (int b = 10; b >= 0; b--) begin
      t = r | (1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  // External core model: floor sqrt, SQRT_LAT registers deep
  logic [Q_W-1:0] s1 = '0, s2 = '0, s3 = '0;
  always @(posedge clk_fs) begin
    s1 <= Q_W'(isqrt(int'(sqrt_radical)));
    s2 <= s1;
    s3 <= s2;
  end
  assign sqrt_q = s3;

  int cyc = 0;
  always @(posedge clk_fs) cyc <= cyc + 1;

  typedef struct {
    int             ch;
    logic [Q_W-1:0] val;
    int             at;
  } sb_t;
  sb_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  always @(negedge clk_fs) begin
    sb_t e;
    if (rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        if (rms_valid[k]) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_valid ch=%0d value=%0d cycle=%0d, required: no result", k, rms_bus[k*Q_W +: Q_W], cyc);
          end else begin
            e = sb.pop_front();
            if (k !== e.ch || rms_bus[k*Q_W +: Q_W] !== e.val || cyc !== e.at) begin
              n_err++;
              $display("FAIL result got ch=%0d val=%0d cyc=%0d, required ch=%0d val=%0d cyc=%0d",
                       k, rms_bus[k*Q_W +: Q_W], cyc, e.ch, e.val, e.at);
            end
          end
        end
      end
    end
  end

  task automatic set_rad(input int k, input int v);
    radical_bus[k*RAD_W +: RAD_W] = RAD_W'(v);
  endtask

  task automatic push_exp(input int k);
    sb_t e;
    e.ch  = k;
    e.val = Q_W'(isqrt(int'(radical_bus[k*RAD_W +: RAD_W])));
    e.at  = cyc + SQRT_LAT + 1;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk_fs);
    rst_n = 1'b0;
    req = '0;
    sb.delete();
    repeat (2) @(negedge clk_fs);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    repeat (SQRT_LAT + 3) @(negedge clk_fs);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain pending=%0d, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_fs);
    n_cmp++;
    if (ack !== '0 || rms_valid !== '0 || irq !== 1'b0 || sqrt_radical !== '0 || rms_bus !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs ack=%b vld=%b irq=%b rad=%0d rms=%h busy=%b, required all 0",
               ack, rms_valid, irq, sqrt_radical, rms_bus, busy);
    end
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk_fs);
    n_cmp++;
    if (ack !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle ack=%b busy=%b, required 0/0", ack, busy);
    end
  endtask

  task automatic test_single();
    set_rad(2, 400);
    req = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_fs);
      n_cmp++;
      if (ack !== ((i == 0) ? 4'b0100 : 4'b0000) || irq !== 1'b0) begin
        n_err++;
        $display("FAIL single_ack i=%0d ack=%b irq=%b, required ack=%b irq=0", i, ack, irq, (i == 0) ? 4'b0100 : 4'b0000);
      end
      if (i == 0) begin
        n_cmp++;
        if (sqrt_radical !== 22'd400) begin
          n_err++;
          $display("FAIL single_radical got=%0d, required 400", sqrt_radical);
        end
        push_exp(2);
        req = '0;
      end
    end
    n_cmp++;
    if (rms_bus[0 +: Q_W] !== '0 || rms_bus[Q_W +: Q_W] !== '0 || rms_bus[3*Q_W +: Q_W] !== '0 || rms_bus[2*Q_W +: Q_W] !== 11'd20) begin
      n_err++;
      $display("FAIL single_slices rms_bus=%h, required slice2=20 others 0", rms_bus);
    end
    drain("single");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < N_CH; k++) set_rad(k, (k + 1) * (k + 1));
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_fs);
      n_cmp++;
      if (ack !== ((i < 4) ? 4'(1 << i) : 4'b0000)) begin
        n_err++;
        $display("FAIL b2b_ack i=%0d got=%b, required=%b", i, ack, (i < 4) ? 4'(1 << i) : 4'b0000);
      end
      n_cmp++;
      if (irq !== (i == 8)) begin
        n_err++;
        $display("FAIL b2b_irq i=%0d got=%b, required=%b", i, irq, (i == 8));
      end
      if (i < 4) begin
        push_exp(i);
        req[i] = 1'b0;
      end
    end
    drain("b2b");
  endtask

  task automatic test_fairness();
    int exp_ch [10] = '{0, -1, 0, -1, 0, 1, 0, 1, 0, 1};
    logic [3:0] want;
    set_rad(0, 100);
    set_rad(1, 49);
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_fs);
      want = (exp_ch[i] < 0) ? 4'b0000 : 4'(1 << exp_ch[i]);
      n_cmp++;
      if (ack !== want) begin
        n_err++;
        $display("FAIL rr_order i=%0d got=%b, required=%b", i, ack, want);
      end
      if (exp_ch[i] >= 0) push_exp(exp_ch[i]);
      if (i == 4) req[1] = 1'b1;
      if (i == 9) req = '0;
    end
    drain("rr");
  endtask

  task automatic test_enable_gate();
    do_reset();
    set_rad(3, 25);
    set_rad(0, 36);
    set_rad(2, 64);
    req = 4'b1000;
    @(negedge clk_fs);
    n_cmp++;
    if (ack !== 4'b1000) begin
      n_err++;
      $display("FAIL en_inflight_ack got=%b, required=1000", ack);
    end
    push_exp(3);
    req = 4'b0101;
    en = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_fs);
      n_cmp++;
      if (ack !== 4'b0000 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL en_hold i=%0d ack=%b busy=%b, required ack=0000 busy=1", i, ack, busy);
      end
    end
    en = 1'b1;
    @(negedge clk_fs);
    n_cmp++;
    if (ack !== 4'b0001) begin
      n_err++;
      $display("FAIL en_resume_first got=%b, required=0001", ack);
    end
    push_exp(0);
    req[0] = 1'b0;
    @(negedge clk_fs);
    n_cmp++;
    if (ack !== 4'b0100) begin
      n_err++;
      $display("FAIL en_resume_second got=%b, required=0100", ack);
    end
    push_exp(2);
    req[2] = 1'b0;
    drain("en");
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL en_idle_busy got=%b, required 0", busy);
    end
  endtask

  task automatic test_midflight_reset();
    set_rad(2, 900);
    req = 4'b0100;
    @(negedge clk_fs);
    n_cmp++;
    if (ack !== 4'b0100) begin
      n_err++;
      $display("FAIL rst_pre_ack got=%b, required=0100", ack);
    end
    req = '0;
    @(negedge clk_fs);
    @(negedge clk_fs);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ack !== '0 || rms_valid !== '0 || irq !== 1'b0 || sqrt_radical !== '0 || rms_bus !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async ack=%b vld=%b irq=%b rad=%0d rms=%h busy=%b, required all 0",
               ack, rms_valid, irq, sqrt_radical, rms_bus, busy);
    end
    repeat (2) @(negedge clk_fs);
    rst_n = 1'b1;
    repeat (6) @(negedge clk_fs);
    set_rad(1, 121);
    set_rad(3, 144);
    req = 4'b1010;
    @(negedge clk_fs);
    n_cmp++;
    if (ack !== 4'b0010) begin
      n_err++;
      $display("FAIL rst_rr_first got=%b, required=0010", ack);
    end
    push_exp(1);
    req[1] = 1'b0;
    @(negedge clk_fs);
    n_cmp++;
    if (ack !== 4'b1000) begin
      n_err++;
      $display("FAIL rst_rr_second got=%b, required=1000", ack);
    end
    push_exp(3);
    req[3] = 1'b0;
    drain("rst");
  endtask

  task automatic test_extremes();
    set_rad(0, 22'h3FFFFF);
    set_rad(1, 0);
    req = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_fs);
      n_cmp++;
      if (ack !== 4'(1 << i)) begin
        n_err++;
        $display("FAIL ext_ack i=%0d got=%b, required=%b", i, ack, 4'(1 << i));
      end
      push_exp(i);
      req[i] = 1'b0;
    end
    drain("ext");
    n_cmp++;
    if (rms_bus[0 +: Q_W] !== 11'd2047 || rms_bus[Q_W +: Q_W] !== 11'd0) begin
      n_err++;
      $display("FAIL ext_values slice0=%0d slice1=%0d, required 2047/0", rms_bus[0 +: Q_W], rms_bus[Q_W +: Q_W]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_enable_gate();
    test_midflight_reset();
    test_extremes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
